edf_scheduler: RTL
==================

EDF_SCHEDULER -- requirements
Module: edf_scheduler

Interface
REQ-001 SHALL have parameter NUMBER_OF_QUEUES, default 4: number of per-core queues arbitrated.
REQ-002 SHALL have parameter REGISTER_SIZE, default 32: width of period and time registers.
REQ-003 SHALL have parameter DATA_SIZE, default 678: packet width.
REQ-004 SHALL have port clock, input, 1: single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port queues_period, input, NUMBER_OF_QUEUES x REGISTER_SIZE: relative deadline per queue, in cycles.
REQ-007 SHALL have port empty, input, NUMBER_OF_QUEUES: per-queue empty flags from the queueing domain.
REQ-008 SHALL have port scheduler_to_queues_ready, output, 1: one-cycle pop request to the queueing domain.
REQ-009 SHALL have port core_id, output, clog2(NUMBER_OF_QUEUES): selected queue index.
REQ-010 SHALL have port queues_to_serializer_valid, input, 1: one-cycle pulse marking the popped packet.
REQ-011 SHALL have port queues_to_serializer_packet, input, DATA_SIZE: popped packet.
REQ-012 SHALL have port serializer_packet, output, DATA_SIZE: registered packet to the serializer.
REQ-013 SHALL have port serializer_valid, output, 1: packet offered; held until accepted.
REQ-014 SHALL have port serializer_ready, input, 1: serializer accepts when high together with serializer_valid.

Function
REQ-015 SHALL run a free-running REGISTER_SIZE time counter, +1 per cycle, wrapping modulo 2^REGISTER_SIZE.
REQ-016 SHALL keep an absolute deadline per queue; slack = deadline - time, interpreted as signed REGISTER_SIZE (wrap-safe).
REQ-017 SHALL implement FSM IDLE -> SELECT -> REQUEST -> WAIT_VALID -> OUTPUT -> IDLE.
REQ-018 IDLE: when any empty bit is 0, go to SELECT next cycle; otherwise stay.
REQ-019 SELECT: register core_id = non-empty queue with minimum slack; tie -> lowest index; empty sampled only this cycle.
REQ-020 REQUEST: drive scheduler_to_queues_ready high for exactly one cycle, then WAIT_VALID; ready is low in all other states, so every request is a fresh rising edge.
REQ-021 core_id SHALL stay constant from the cycle after SELECT until the packet is captured.
REQ-022 WAIT_VALID: on queues_to_serializer_valid, capture packet into serializer_packet, set deadline[core_id] = time + queues_period[core_id] (truncated), enter OUTPUT.
REQ-023 OUTPUT: serializer_valid high and serializer_packet stable until serializer_ready; on acceptance drop valid and go to IDLE.
REQ-024 Latency from non-empty in IDLE to ready pulse: 2 cycles; valid pulse in non-WAIT_VALID states is ignored.
REQ-025 queues_period of 0 SHALL make the deadline equal to the service time (always due).

Reset
REQ-026 On reset low: FSM = IDLE, time = 0, all deadlines = 0, core_id = 0, scheduler_to_queues_ready = 0, serializer_valid = 0, serializer_packet = 0; asserting it in any state aborts the transaction with no further ready or valid.

Configuration
REQ-027 Macro EDF_SCHEDULER_STATS_EN: when defined, adds per-queue REGISTER_SIZE saturating outputs served_count and miss_count (miss = slack < 0 at capture), both reset to 0; when undefined, those ports and counters do not exist and behaviour is otherwise identical.

Structure
REQ-028 Package edf_pkg SHALL hold the FSM state enum and the signed slack type.
REQ-029 Sub-module edf_argmin SHALL compute the combinational minimum-slack index over non-empty queues with lowest-index tie break.

Verification
REQ-030 After reset, empty=4'b1011: ready pulses 2 cycles later with core_id=2; valid with packet 0xABC gives serializer_packet=0xABC, serializer_valid held.
REQ-031 Periods {100,50,200,400}, all queues non-empty, deadlines 0: first grant core 0 (tie); next grant core 1 (deadline t+0 still below core 0's t+100).
REQ-032 serializer_ready held low 10 cycles: serializer_valid and packet stable for all 10; no new ready pulse until acceptance.
REQ-033 Time preset near 0xFFFF_FFF0, queue 3 deadline wraps to 0x0000_0020, queue 1 deadline 0xFFFF_FFF8: queue 1 chosen.
REQ-034 Reset asserted in WAIT_VALID: outputs zero immediately; a valid pulse arriving afterwards produces no serializer_valid.
REQ-035 With EDF_SCHEDULER_STATS_EN, queue 0 period 5 served after 20 idle cycles: miss_count[0]=1, served_count[0]=1.

Source files
------------

// File: rtl/edf_pkg.sv
// Shared types for the EDF scheduler: FSM state encoding and the signed slack type.
// Slack is carried 64 bits wide so any REGISTER_SIZE up to 64 sign-extends into it losslessly.
package edf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SELECT     = 3'd1,
    ST_REQUEST    = 3'd2,
    ST_WAIT_VALID = 3'd3,
    ST_OUTPUT     = 3'd4
  } state_e;

  localparam int SLACK_W = 64;
  typedef logic signed [SLACK_W-1:0] slack_t;

endpackage

// File: rtl/edf_argmin.sv
// Combinational minimum-slack index over the valid (non-empty) queues; ties go to the lowest index.
// Zero latency; no flow control, found_vld is low when no queue is valid.
module edf_argmin
  import edf_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  slack_t        slack [N],
  output logic [IW-1:0] idx,
  output logic          found_vld
);

  slack_t best;

  // Strict less-than keeps the earliest index on equal slack.
  always_comb begin
    idx       = '0;
    found_vld = 1'b0;
    best      = '0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && (!found_vld || (slack[i] < best))) begin
        found_vld = 1'b1;
        best      = slack[i];
        idx       = IW'(i);
      end
    end
  end

endmodule

// File: rtl/edf_scheduler.sv
// Earliest-deadline-first pop scheduler: ready pulse 2 cycles after a non-empty queue is seen in IDLE,
// output held until serializer_ready. Optional per-queue stats counters under EDF_SCHEDULER_STATS_EN.
module edf_scheduler
  import edf_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32,
  parameter int DATA_SIZE        = 678,
  localparam int IW = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]  queues_period,
  input  logic [NUMBER_OF_QUEUES-1:0]                     empty,
  output logic                                            scheduler_to_queues_ready,
  output logic [IW-1:0]                                   core_id,
  input  logic                                            queues_to_serializer_valid,
  input  logic [DATA_SIZE-1:0]                            queues_to_serializer_packet,
  output logic [DATA_SIZE-1:0]                            serializer_packet,
  output logic                                            serializer_valid,
  input  logic                                            serializer_ready
`ifdef EDF_SCHEDULER_STATS_EN
  ,
  output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]  served_count,
  output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]  miss_count
`endif
);

  state_e                   state_q, state_d;
  logic [REGISTER_SIZE-1:0] time_q, time_d;
  logic [REGISTER_SIZE-1:0] deadline_q [NUMBER_OF_QUEUES];
  logic [REGISTER_SIZE-1:0] deadline_d [NUMBER_OF_QUEUES];
  logic [IW-1:0]            core_id_q, core_id_d;
  logic                     ready_q, ready_d;
  logic                     svalid_q, svalid_d;
  logic [DATA_SIZE-1:0]     spacket_q, spacket_d;

  slack_t        slack [NUMBER_OF_QUEUES];
  logic [IW-1:0] sel_idx;
  logic          sel_vld;
  logic          cap_vld;

  // Modular difference reinterpreted as signed keeps the ordering correct across counter wrap.
  for (genvar g = 0; g < NUMBER_OF_QUEUES; g++) begin : g_slack
    logic [REGISTER_SIZE-1:0] diff;
    assign diff     = deadline_q[g] - time_q;
    assign slack[g] = slack_t'($signed(diff));
  end

  edf_argmin #(.N(NUMBER_OF_QUEUES)) u_argmin (
    .valid     (~empty),
    .slack     (slack),
    .idx       (sel_idx),
    .found_vld (sel_vld)
  );

  assign cap_vld = (state_q == ST_WAIT_VALID) && queues_to_serializer_valid;

  always_comb begin
    state_d    = state_q;
    time_d     = time_q + 1'b1;
    deadline_d = deadline_q;
    core_id_d  = core_id_q;
    ready_d    = 1'b0;
    svalid_d   = svalid_q;
    spacket_d  = spacket_q;
    case (state_q)
      ST_IDLE: begin
        if (!(&empty)) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        // Queues may drain between IDLE and SELECT; fall back rather than pop an empty queue.
        if (sel_vld) begin
          core_id_d = sel_idx;
          ready_d   = 1'b1;
          state_d   = ST_REQUEST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQUEST: begin
        state_d = ST_WAIT_VALID;
      end
      ST_WAIT_VALID: begin
        if (cap_vld) begin
          spacket_d             = queues_to_serializer_packet;
          deadline_d[core_id_q] = time_q + queues_period[core_id_q];
          svalid_d              = 1'b1;
          state_d               = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (serializer_ready) begin
          svalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      time_q     <= '0;
      deadline_q <= '{default: '0};
      core_id_q  <= '0;
      ready_q    <= 1'b0;
      svalid_q   <= 1'b0;
      spacket_q  <= '0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      deadline_q <= deadline_d;
      core_id_q  <= core_id_d;
      ready_q    <= ready_d;
      svalid_q   <= svalid_d;
      spacket_q  <= spacket_d;
    end
  end

  assign scheduler_to_queues_ready = ready_q;
  assign core_id                   = core_id_q;
  assign serializer_valid          = svalid_q;
  assign serializer_packet         = spacket_q;

`ifdef EDF_SCHEDULER_STATS_EN
  logic [REGISTER_SIZE-1:0] served_q [NUMBER_OF_QUEUES];
  logic [REGISTER_SIZE-1:0] served_d [NUMBER_OF_QUEUES];
  logic [REGISTER_SIZE-1:0] miss_q   [NUMBER_OF_QUEUES];
  logic [REGISTER_SIZE-1:0] miss_d   [NUMBER_OF_QUEUES];

  // A miss is a capture whose queue was already past its deadline.
  always_comb begin
    served_d = served_q;
    miss_d   = miss_q;
    if (cap_vld) begin
      if (served_q[core_id_q] != '1) served_d[core_id_q] = served_q[core_id_q] + 1'b1;
      if (slack[core_id_q][SLACK_W-1] && (miss_q[core_id_q] != '1))
        miss_d[core_id_q] = miss_q[core_id_q] + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      served_q <= '{default: '0};
      miss_q   <= '{default: '0};
    end else begin
      served_q <= served_d;
      miss_q   <= miss_d;
    end
  end

  for (genvar g = 0; g < NUMBER_OF_QUEUES; g++) begin : g_stats
    assign served_count[g] = served_q[g];
    assign miss_count[g]   = miss_q[g];
  end
`endif

endmodule
